logic_accum: RTL and testbench
==============================

LOGIC_ACCUM -- requirements
Module: logic_accum

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width in bits (legal range 1..64).
REQ-002 Parameter COUNT_W, default 8, SHALL set the beat-counter width in bits (legal range 1..16).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 op  input  2  SHALL select the operation: 00 OR, 01 AND, 10 XOR, 11 NOR.
REQ-006 in_valid  input  1  SHALL indicate that the upstream beat is valid.
REQ-007 in_ready  output  1  SHALL indicate that the block can accept a beat.
REQ-008 in_data  input  WIDTH  SHALL carry the operand word.
REQ-009 in_last  input  1  SHALL mark the final beat of a packet.
REQ-010 out_valid  output  1  SHALL indicate that a result is available.
REQ-011 out_ready  input  1  SHALL indicate that downstream accepts the result.
REQ-012 out_data  output  WIDTH  SHALL carry the packet result.
REQ-013 out_count  output  COUNT_W  SHALL report the number of beats in the packet; this port is present only under REQ-031.

Function
REQ-014 The block SHALL implement a state machine with three states: IDLE, ACCUM and DONE.
REQ-015 A beat SHALL be accepted exactly when in_valid=1 and in_ready=1 in the same cycle.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in DONE.
REQ-017 out_valid SHALL be 1 only in DONE.
REQ-018 On an accepted beat in IDLE, the block SHALL:
- load acc with in_data (for op=11, with ~in_data);
- latch op;
- set count to 1;
- go to DONE if in_last=1, otherwise go to ACCUM.
REQ-019 On an accepted beat in ACCUM, the block SHALL update acc with the latched op:
- OR: acc <= acc | in_data;
- AND: acc <= acc & in_data;
- XOR: acc <= acc ^ in_data;
- NOR: acc <= acc & ~in_data (i.e. NOR of all beats);
- go to DONE if in_last=1.
REQ-020 op SHALL be sampled only on the first beat of a packet; changes to op during a packet SHALL be ignored.
REQ-021 In ACCUM, count SHALL increment by 1 per accepted beat and saturate at 2^COUNT_W-1.
REQ-022 A cycle with no accepted beat SHALL leave acc, count and state unchanged.
REQ-023 Latency: out_valid SHALL rise in the cycle after the cycle that accepts the last beat.
REQ-024 In DONE, out_data SHALL equal acc, and out_data and out_count SHALL stay stable until the result is accepted.
REQ-025 In DONE, out_valid=1 and out_ready=1 SHALL move the state to IDLE at the next edge; the minimum gap between the last beats of consecutive packets SHALL therefore be one bubble cycle.
REQ-026 No combinational path SHALL exist from out_ready to in_ready or to any other output.
REQ-027 in_data and in_last SHALL be ignored in any cycle with no accepted beat.

Reset
REQ-028 Asserting reset SHALL, at the next rising edge, force state=IDLE, acc=0, count=0, out_valid=0 and in_ready=1.
REQ-029 reset SHALL take priority over every other input, including a simultaneous beat acceptance or result handshake.
REQ-030 Reset during ACCUM or DONE SHALL discard the partial or pending packet; no result from it SHALL ever appear on the outputs.

Configuration
REQ-031 With macro LOGIC_ACCUM_COUNT_EN defined:
- the out_count port SHALL exist;
- the beat counter SHALL be implemented;
- out_count SHALL equal count while in DONE and 0 otherwise.
REQ-032 With LOGIC_ACCUM_COUNT_EN undefined, neither the out_count port nor any counter logic SHALL exist; all other behaviour SHALL be identical.

Verification (WIDTH=8, LOGIC_ACCUM_COUNT_EN defined)
REQ-033 Single beat, op=00, in_data=8'hA0, in_last=1 -> next cycle out_valid=1, out_data=8'hA0, out_count=1.
REQ-034 op=00, beats 8'h0F then 8'hF0 (last) -> out_data=8'hFF, out_count=2; op=10, beats 8'h55 then 8'hFF -> out_data=8'hAA.
REQ-035 op=01, beats 8'hFF, 8'h3C, 8'h0C (last), with op changed to 00 after beat 1 -> out_data=8'h0C, out_count=3.
REQ-036 Result pending with out_ready=0 for 5 cycles -> out_valid=1, out_data stable, in_ready=0 throughout; out_ready=1 for one cycle -> next cycle out_valid=0, in_ready=1.
REQ-037 op=00, beat 8'h01 accepted, then reset for 1 cycle, then a single beat 8'h80 (last) -> out_data=8'h80, out_count=1.
REQ-038 op=00, beats 8'h01 and 8'h02 (last), with reset asserted in the same cycle as the last beat -> no out_valid ever; state=IDLE.

Source files
------------

// File: rtl/logic_accum.sv
// Packet-wide bitwise reduction (OR/AND/XOR/NOR) over a valid/ready beat stream.
// Optional beat counter and out_count port are enabled by defining LOGIC_ACCUM_COUNT_EN.
module logic_accum #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef LOGIC_ACCUM_COUNT_EN
  ,
  output logic [COUNT_W-1:0] out_count
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
  typedef enum logic [1:0] {OP_OR, OP_AND, OP_XOR, OP_NOR} op_e;

  if (WIDTH < 1 || WIDTH > 64 || COUNT_W < 1 || COUNT_W > 16) begin : g_param_check
    $error("logic_accum: WIDTH must be 1..64 and COUNT_W 1..16");
  end

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] acc;
  logic             accept;

  assign accept   = in_valid && in_ready;
  assign out_data = acc;

  // in_ready and out_valid are flops written alongside state, so out_ready
  // only ever reaches outputs through a clock edge.
  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create ordering-dependent behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_OR;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_q <= op_e'(op);
          acc  <= (op_e'(op) == OP_NOR) ? ~in_data : in_data;
          if (in_last) begin
            state     <= DONE;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            state <= ACCUM;
          end
        end
        ACCUM: if (accept) begin
          unique case (op_q)
            OP_OR:  acc <= acc | in_data;
            OP_AND: acc <= acc & in_data;
            OP_XOR: acc <= acc ^ in_data;
            OP_NOR: acc <= acc & ~in_data;
          endcase
          if (in_last) begin
            state     <= DONE;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOGIC_ACCUM_COUNT_EN
  logic [COUNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (accept) begin
      if (state == IDLE)
        count <= COUNT_W'(1);
      else if (count != '1)
        count <= count + COUNT_W'(1);
    end
  end

  assign out_count = out_valid ? count : '0;
`endif

endmodule

// File: tb/tb_logic_accum.sv
// Scoreboard bench for logic_accum: stimulus pushes expected results, a
// negedge monitor pops and compares on every output handshake.
module tb_logic_accum;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef LOGIC_ACCUM_COUNT_EN
  logic [7:0] out_count;
`endif

  logic_accum #(.WIDTH(8), .COUNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef LOGIC_ACCUM_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] count;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: any out_valid with nothing expected is an error; on handshake pop and compare.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got data %0h with no result expected", out_data);
      end else if (out_ready) begin
        exp_t e;
        e = sb.pop_front();
        check("result_data", 64'(out_data), 64'(e.data));
`ifdef LOGIC_ACCUM_COUNT_EN
        check("result_count", 64'(out_count), 64'(e.count));
`endif
      end
    end
  end

  task automatic expect_result(input logic [7:0] d, input logic [7:0] c);
    exp_t e;
    e.data  = d;
    e.count = c;
    sb.push_back(e);
  endtask

  // Present one beat, wait (bounded) for in_ready, let it be accepted at the next edge.
  task automatic beat(input logic [1:0] o, input logic [7:0] d, input logic l);
    int n;
    op       = o;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hxx;
    in_last  = 1'bx;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    op        = 2'b00;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    idle_cycles(2);
    reset = 1'b0;

    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data",  64'(out_data),  64'd0);
`ifdef LOGIC_ACCUM_COUNT_EN
    check("reset_out_count", 64'(out_count), 64'd0);
`endif

    // Single beat OR; result must appear the very next cycle.
    expect_result(8'hA0, 8'd1);
    beat(2'b00, 8'hA0, 1'b1);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    check("latency_in_ready",  64'(in_ready),  64'd0);
    idle_cycles(1);
    check("after_accept_out_valid", 64'(out_valid), 64'd0);

    // OR then XOR packets issued back to back.
    expect_result(8'hFF, 8'd2);
    beat(2'b00, 8'h0F, 1'b0);
    beat(2'b00, 8'hF0, 1'b1);
    expect_result(8'hAA, 8'd2);
    beat(2'b10, 8'h55, 1'b0);
    beat(2'b10, 8'hFF, 1'b1);

    // AND with op changed mid-packet: change must be ignored.
    expect_result(8'h0C, 8'd3);
    beat(2'b01, 8'hFF, 1'b0);
    beat(2'b00, 8'h3C, 1'b0);
    beat(2'b00, 8'h0C, 1'b1);

    // NOR: single beat, then two beats (~0F & ~30 = C0).
    expect_result(8'hA5, 8'd1);
    beat(2'b11, 8'h5A, 1'b1);
    expect_result(8'hC0, 8'd2);
    beat(2'b11, 8'h0F, 1'b0);
    beat(2'b11, 8'h30, 1'b1);

    // Backpressure: result held for 5 cycles with out_ready low.
    idle_cycles(2);
    out_ready = 1'b0;
    expect_result(8'h3C, 8'd1);
    beat(2'b00, 8'h3C, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_data",  64'(out_data),  64'h3C);
      check("stall_in_ready",  64'(in_ready),  64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready",  64'(in_ready),  64'd1);

    // Reset in the middle of a packet discards it.
    beat(2'b00, 8'h01, 1'b0);
    reset = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    expect_result(8'h80, 8'd1);
    beat(2'b00, 8'h80, 1'b1);
    idle_cycles(2);

    // Reset coincident with the last beat: no result ever.
    beat(2'b00, 8'h01, 1'b0);
    op       = 2'b00;
    in_data  = 8'h02;
    in_last  = 1'b1;
    in_valid = 1'b1;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    idle_cycles(5);
    check("reset_last_out_valid", 64'(out_valid), 64'd0);
    check("reset_last_in_ready",  64'(in_ready),  64'd1);
    check("reset_last_out_data",  64'(out_data),  64'd0);

    // Count saturation: 260 beats saturate an 8-bit count at 255.
    expect_result(8'h81, 8'd255);
    for (int i = 0; i < 259; i++) beat(2'b00, 8'h01, 1'b0);
    beat(2'b00, 8'h80, 1'b1);
    idle_cycles(3);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
